key_sel_debounce: RTL and testbench
===================================

Name: key_sel_debounce

Overview:
- Receiving end of the active-low waveform-select key driven into the DDS top.
- Synchronises and debounces ikey_sel_n, then emits one-cycle press and release pulses.
- Owns the waveform-select register that steps through the available DDS waveforms on each validated press.
- Sits between the key pad and the phase-accumulator/waveform-ROM mux, clocked in the PLL system clock domain.

Parameters:
- DEB_CNT, 8: consecutive stable synchronised samples required to accept a press or a release.
- WAVE_NUM, 4: number of selectable waveforms. owave_sel wraps at WAVE_NUM-1.
- LONG_CNT, 1024: held cycles after press acceptance that mark a long press. Used only with the optional feature.

Ports:
- iclk  input  1  system clock (PLL output).
- irstn  input  1  synchronous, active-low reset, sampled on rising iclk.
- ikey_sel_n  input  1  raw select key, 0 = pressed, asynchronous to iclk.
- opress_pulse  output  1  one-cycle strobe when a press is accepted.
- orelease_pulse  output  1  one-cycle strobe when a release is accepted.
- okey_state  output  1  debounced level, 1 = pressed.
- owave_sel  output  2  current waveform code: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- olong_pulse  output  1  one-cycle long-press strobe. Constant 0 without the optional feature.

Behaviour:
- Reset:
  - One clock, iclk. Reset is synchronous, active-low (irstn); it takes effect only on a rising iclk edge while irstn=0.
  - In reset: both sync flops=1, state=IDLE, counters=0, all pulses=0, okey_state=0, owave_sel=0.
- Synchroniser: 2-flop chain on ikey_sel_n. Only the second flop (key_s) feeds the FSM.
- Debounce counter: width $clog2(DEB_CNT).
- FSM states and transitions:
  - IDLE: key_s=0 -> PRESS_DB, cnt<=0.
  - PRESS_DB: key_s=1 -> IDLE (glitch, no pulse). Else if cnt==DEB_CNT-1 -> HELD, opress_pulse<=1, okey_state<=1, owave_sel advances. Else cnt++.
  - HELD: key_s=1 -> RELEASE_DB, cnt<=0.
  - RELEASE_DB: key_s=0 -> HELD (bounce, no pulse). Else if cnt==DEB_CNT-1 -> IDLE, orelease_pulse<=1, okey_state<=0. Else cnt++.
- Latency: opress_pulse is high for the cycle after the (DEB_CNT+3)th rising edge, counting the first edge that samples ikey_sel_n=0. Release latency is the same.
- Pulses are registered and high for exactly one cycle. A press cannot fire again until a release has been accepted.
- owave_sel arithmetic: increments by 1. WAVE_NUM-1 wraps to 0. No other source changes it except reset and the optional feature.
- Reset mid-debounce or while HELD: returns to IDLE immediately. No pulse is emitted on reset exit. A key still held after reset must re-qualify through PRESS_DB.
- A constantly low key at reset release produces exactly one press after the qualify latency.

Optional Feature:
- Macro: KEY_SEL_LONGPRESS_EN.
- Defined:
  - A long counter, width $clog2(LONG_CNT), runs in HELD. It is cleared on entry to HELD.
  - When it reaches LONG_CNT-1: olong_pulse=1 for one cycle and owave_sel<=0. Fires once per press.
  - A press/release bounce (HELD->RELEASE_DB->HELD) does not clear the long counter.
- Undefined: no long counter is built, olong_pulse is tied to 0, and owave_sel changes only on presses.

Decomposition:
- Package key_sel_pkg holds:
  - state enum: IDLE=2'd0, PRESS_DB=2'd1, HELD=2'd2, RELEASE_DB=2'd3.
  - wave codes: WAVE_SINE=0, WAVE_SQUARE=1, WAVE_TRI=2, WAVE_SAW=3.
- Sub-module key_sync: the 2-flop synchroniser, parameterised reset value 1. Instantiated once.

Test Plan:
- Reset then idle: irstn low for 3 cycles, key high for 100 cycles -> all outputs 0, owave_sel=0.
- Clean press: key low for 20 cycles -> one opress_pulse on edge 11 (DEB_CNT=8), owave_sel 0->1. Release -> one orelease_pulse 11 edges after key rises.
- Glitch: key low for 5 cycles, then high -> no pulse, state returns to IDLE, owave_sel unchanged. Release bounce 0-1-0 while held -> no orelease_pulse.
- Wrap: 5 clean presses (low 10, high 2048, mirroring the system bench cadence) -> owave_sel sequence 1,2,3,0,1, with exactly 5 press pulses.
- Reset mid-operation: irstn=0 while in PRESS_DB at cnt=4 -> next edge state=IDLE, owave_sel=0, no pulses. Key still low -> press accepted 11 edges after reset release.
- KEY_SEL_LONGPRESS_EN, LONG_CNT=16:
  - Press held 40 cycles with owave_sel=2 -> opress_pulse (owave_sel=3), then olong_pulse 16 cycles later with owave_sel=0, once only.
  - Without the macro -> olong_pulse stays 0.

Source files
------------

// File: rtl/key_sel_pkg.sv
// Shared types for the waveform-select key: debounce FSM states, waveform codes
// and the waveform-step helper.
package key_sel_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_e;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  // Next waveform code; the last available waveform wraps back to sine.
  function automatic logic [1:0] wave_next(input logic [1:0] cur, input int unsigned wave_num);
    if (32'(cur) >= wave_num - 32'd1) return WAVE_SINE;
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the asynchronous key input; both flops reset to RST_VAL.
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic iclk,
  input  logic irstn,
  input  logic id,
  output logic oq
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= id;
      sync_q <= meta_q;
    end
  end

  assign oq = sync_q;

endmodule

// File: rtl/key_sel_debounce.sv
// Debounces the active-low waveform-select key and steps the waveform register on each press.
// Optional long-press return-to-sine is enabled with KEY_SEL_LONGPRESS_EN.
module key_sel_debounce
  import key_sel_pkg::*;
#(
  parameter int unsigned DEB_CNT  = 8,
  parameter int unsigned WAVE_NUM = 4,
  parameter int unsigned LONG_CNT = 1024
) (
  input  logic       iclk,
  input  logic       irstn,
  input  logic       ikey_sel_n,
  output logic       opress_pulse,
  output logic       orelease_pulse,
  output logic       okey_state,
  output logic [1:0] owave_sel,
  output logic       olong_pulse
);

  localparam int unsigned CNT_W  = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int unsigned LONG_W = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;

  logic key_s;

  key_sync #(.RST_VAL(1'b1)) u_key_sync (
    .iclk  (iclk),
    .irstn (irstn),
    .id    (ikey_sel_n),
    .oq    (key_s)
  );

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             key_state_q, key_state_d;
  logic [1:0]       wave_q, wave_d;
  logic             long_pulse_q, long_pulse_d;
`ifdef KEY_SEL_LONGPRESS_EN
  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_done_q, long_done_d;
`endif

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      key_state_q  <= 1'b0;
      wave_q       <= WAVE_SINE;
      long_pulse_q <= 1'b0;
`ifdef KEY_SEL_LONGPRESS_EN
      long_cnt_q   <= '0;
      long_done_q  <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
      release_q    <= release_d;
      key_state_q  <= key_state_d;
      wave_q       <= wave_d;
      long_pulse_q <= long_pulse_d;
`ifdef KEY_SEL_LONGPRESS_EN
      long_cnt_q   <= long_cnt_d;
      long_done_q  <= long_done_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    key_state_d  = key_state_q;
    wave_d       = wave_q;
    long_pulse_d = 1'b0;
`ifdef KEY_SEL_LONGPRESS_EN
    long_cnt_d   = long_cnt_q;
    long_done_d  = long_done_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
          state_d     = HELD;
          press_d     = 1'b1;
          key_state_d = 1'b1;
          wave_d      = wave_next(wave_q, WAVE_NUM);
`ifdef KEY_SEL_LONGPRESS_EN
          long_cnt_d  = '0;
          long_done_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (!key_s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          key_state_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef KEY_SEL_LONGPRESS_EN
    // Long counter only advances in HELD, so a release bounce pauses it without clearing it.
    if (state_q == HELD && !long_done_q) begin
      if (long_cnt_q == LONG_W'(LONG_CNT - 1)) begin
        long_pulse_d = 1'b1;
        long_done_d  = 1'b1;
        wave_d       = WAVE_SINE;
      end else begin
        long_cnt_d = long_cnt_q + LONG_W'(1);
      end
    end
`endif
  end

`ifndef KEY_SEL_LONGPRESS_EN
  // Long-press width is irrelevant when the feature is not built.
  logic unused_long_c;
  assign unused_long_c = ^LONG_W;
`endif

  assign opress_pulse   = press_q;
  assign orelease_pulse = release_q;
  assign okey_state     = key_state_q;
  assign owave_sel      = wave_q;
  assign olong_pulse    = long_pulse_q;

endmodule

// File: tb/tb_key_sel_debounce.sv
// Randomised and directed bench for key_sel_debounce against a run-length reference model.
module tb_key_sel_debounce;

  localparam int unsigned DEB_CNT  = 8;
  localparam int unsigned WAVE_NUM = 4;
  localparam int unsigned LONG_CNT = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       key_n;
  logic       press_pulse, release_pulse, key_state, long_pulse;
  logic [1:0] wave_sel;

  always #5 clk = ~clk;

  key_sel_debounce #(
    .DEB_CNT  (DEB_CNT),
    .WAVE_NUM (WAVE_NUM),
    .LONG_CNT (LONG_CNT)
  ) dut (
    .iclk           (clk),
    .irstn          (rstn),
    .ikey_sel_n     (key_n),
    .opress_pulse   (press_pulse),
    .orelease_pulse (release_pulse),
    .okey_state     (key_state),
    .owave_sel      (wave_sel),
    .olong_pulse    (long_pulse)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: key delayed two samples, then a run-length rule on the delayed key.
  bit m_s1, m_s2, m_level;
  int m_run, m_wave, m_long;
  bit m_long_done;
  bit e_press, e_rel, e_long;

  // Observation bookkeeping
  int edge_no = 0;
  int press_edge = -1, rel_edge = -1;
  int n_press = 0, n_rel = 0, n_long = 0;

  task automatic model_step(input logic r, input logic k);
    bit ks;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (!r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0;
      m_run = 0; m_wave = 0; m_long = 0; m_long_done = 1'b1;
      return;
    end
    ks   = m_s2;
    m_s2 = m_s1;
    m_s1 = k;
    if (!m_level) begin
      m_run = (ks == 1'b0) ? m_run + 1 : 0;
      if (m_run == int'(DEB_CNT) + 1) begin
        e_press = 1'b1; m_level = 1'b1; m_run = 0;
        m_wave = (m_wave + 1) % int'(WAVE_NUM);
        m_long = 0; m_long_done = 1'b0;
      end
    end else begin
`ifdef KEY_SEL_LONGPRESS_EN
      // Held and not currently in a release run: long-press time accumulates.
      if (m_run == 0 && !m_long_done) begin
        if (m_long == int'(LONG_CNT) - 1) begin
          e_long = 1'b1; m_long_done = 1'b1; m_wave = 0;
        end else begin
          m_long++;
        end
      end
`endif
      m_run = (ks == 1'b1) ? m_run + 1 : 0;
      if (m_run == int'(DEB_CNT) + 1) begin
        e_rel = 1'b1; m_level = 1'b0; m_run = 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic k);
    rstn  = r;
    key_n = k;
    @(posedge clk);
    model_step(r, k);
    edge_no++;
    #1;
    check("press_pulse",   32'(press_pulse),   32'(e_press));
    check("release_pulse", 32'(release_pulse), 32'(e_rel));
    check("key_state",     32'(key_state),     32'(m_level));
    check("wave_sel",      32'(wave_sel),      32'(m_wave));
    check("long_pulse",    32'(long_pulse),    32'(e_long));
    if (press_pulse === 1'b1) begin n_press++; press_edge = edge_no; end
    if (release_pulse === 1'b1) begin n_rel++; rel_edge = edge_no; end
    if (long_pulse === 1'b1) n_long++;
  endtask

  task automatic hold(input logic k, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, k);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
  endtask

  initial begin
    int mark, p0, wseq[5];
    rstn  = 1'b0;
    key_n = 1'b1;

    // Reset then idle
    do_reset(3);
    check("reset_wave", 32'(wave_sel), 32'd0);
    hold(1'b1, 100);
    check("idle_no_press", 32'(n_press), 32'd0);

    // Clean press and release
    mark = edge_no;
    hold(1'b0, 20);
    check("press_latency", 32'(press_edge - mark), 32'(DEB_CNT + 3));
    check("press_wave", 32'(wave_sel), 32'd1);
    check("press_count", 32'(n_press), 32'd1);
    mark = edge_no;
    hold(1'b1, 20);
    check("release_latency", 32'(rel_edge - mark), 32'(DEB_CNT + 3));
    check("release_count", 32'(n_rel), 32'd1);

    // Press glitch and release bounce
    hold(1'b0, 5);
    hold(1'b1, 20);
    check("glitch_no_press", 32'(n_press), 32'd1);
    check("glitch_wave", 32'(wave_sel), 32'd1);
    hold(1'b0, 20);
    hold(1'b1, 3);
    hold(1'b0, 20);
    check("bounce_no_release", 32'(n_rel), 32'd1);
    check("bounce_held", 32'(key_state), 32'd1);
    hold(1'b1, 20);

    // Wrap through all waveforms
    do_reset(2);
    p0 = n_press;
    for (int i = 0; i < 5; i++) begin
      hold(1'b0, 10);
      hold(1'b1, 2048);
      wseq[i] = int'(wave_sel);
    end
    check("wrap_count", 32'(n_press - p0), 32'd5);
    check("wrap_w0", 32'(wseq[0]), 32'd1);
    check("wrap_w1", 32'(wseq[1]), 32'd2);
    check("wrap_w2", 32'(wseq[2]), 32'd3);
    check("wrap_w3", 32'(wseq[3]), 32'd0);
    check("wrap_w4", 32'(wseq[4]), 32'd1);

    // Reset in the middle of press debounce
    p0 = n_press;
    hold(1'b0, 7);
    cycle(1'b0, 1'b0);
    check("midrst_wave", 32'(wave_sel), 32'd0);
    check("midrst_state", 32'(key_state), 32'd0);
    mark = edge_no;
    hold(1'b0, 20);
    check("midrst_latency", 32'(press_edge - mark), 32'(DEB_CNT + 3));
    check("midrst_count", 32'(n_press - p0), 32'd1);
    hold(1'b1, 20);

    // Long press starting from triangle
    do_reset(2);
    for (int i = 0; i < 2; i++) begin hold(1'b0, 12); hold(1'b1, 14); end
    check("long_pre_wave", 32'(wave_sel), 32'd2);
    p0 = n_long;
    hold(1'b0, 40);
`ifdef KEY_SEL_LONGPRESS_EN
    check("long_count", 32'(n_long - p0), 32'd1);
    check("long_wave", 32'(wave_sel), 32'd0);
`else
    check("long_count", 32'(n_long - p0), 32'd0);
    check("long_wave", 32'(wave_sel), 32'd3);
`endif
    hold(1'b1, 20);

    // Randomised segments with occasional resets
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if ($urandom_range(0, 3) == 0) begin
        hold(1'($urandom_range(0, 1)), int'($urandom_range(DEB_CNT, 60)));
      end else begin
        hold(1'($urandom_range(0, 1)), int'($urandom_range(1, DEB_CNT + 4)));
      end
    end
    hold(1'b1, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
